// File: rtl/demux32_pkg.sv
// Shared constants and state type for the 32-lane collector.
// Optional feature macro used by this block: DEMUX32_AUTO_SEL_EN.
package demux32_pkg;

    localparam int unsigned N_LANES = 32;
    localparam int unsigned SEL_W   = 5;

    localparam logic [N_LANES-1:0] MASK_ALL = '1;

    typedef enum logic [0:0] {
        FILL,
        HOLD
    } state_e;

endpackage

// File: rtl/demux_32_dec.sv
// Combinational 5-to-32 one-hot decoder with enable; drives lane write enables.
module demux_32_dec
    import demux32_pkg::*;
(
    input  logic               en,
    input  logic [SEL_W-1:0]   sel,
    output logic [N_LANES-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_32_collect.sv
// Collects narrow beats into a 32-lane word with a written-lane mask, valid/ready on both sides.
// Optional macro DEMUX32_AUTO_SEL_EN: lane comes from an internal write pointer instead of in_sel.
module demux_32_collect
    import demux32_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [SEL_W-1:0]           in_sel,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_LANES*WIDTH-1:0]   out_data,
    output logic [N_LANES-1:0]         out_mask
);

    state_e                     state_q, state_d;
    logic [N_LANES*WIDTH-1:0]   data_q, data_d;
    logic [N_LANES-1:0]         mask_q, mask_d;
    logic [N_LANES-1:0]         lane_we;
    logic [SEL_W-1:0]           lane_sel;
    logic                       beat;
    logic                       xfer;
    logic                       complete;

`ifdef DEMUX32_AUTO_SEL_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             unused_sel;

    assign unused_sel = ^in_sel;
    assign lane_sel   = ptr_q;
`else
    assign lane_sel   = in_sel;
`endif

    // out_ready -> in_ready is combinational so a draining word can overlap the next beat.
    assign out_valid = (state_q == HOLD);
    assign in_ready  = (state_q == FILL) || out_ready;
    assign beat      = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign out_data  = data_q;
    assign out_mask  = mask_q;

    demux_32_dec u_dec (
        .en     (beat),
        .sel    (lane_sel),
        .onehot (lane_we)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mask_d  = mask_q;

        // A transfer clears first, so a same-cycle beat becomes lane one of the next word.
        if (xfer) begin
            data_d  = '0;
            mask_d  = '0;
            state_d = FILL;
        end

        for (int k = 0; k < int'(N_LANES); k++) begin
            if (lane_we[k]) begin
                data_d[k*WIDTH +: WIDTH] = in_data;
            end
        end
        mask_d = mask_d | lane_we;

        complete = beat && (in_last || (mask_d == MASK_ALL)
`ifdef DEMUX32_AUTO_SEL_EN
                   || (ptr_q == SEL_W'(N_LANES - 1))
`endif
                   );

        if (complete) begin
            state_d = HOLD;
        end
    end

`ifdef DEMUX32_AUTO_SEL_EN
    always_comb begin
        ptr_d = ptr_q;
        if (complete) begin
            ptr_d = '0;
        end else if (beat) begin
            ptr_d = ptr_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            data_q  <= '0;
            mask_q  <= '0;
`ifdef DEMUX32_AUTO_SEL_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
`ifdef DEMUX32_AUTO_SEL_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule

// File: doc/demux_32_collect.md
Name: demux_32_collect

Overview:
- Sequential inverse of the 32:1 select mux used in the DMA library.
- Accepts narrow beats, each steered by a 5-bit lane select into one of 32 lane registers.
- Presents the assembled 32-lane word, plus a per-lane written mask, on a valid/ready output.
- Sits between bit/lane-serial producers and wide-word consumers in the BASIC_DMA64 datapath.

Parameters:
- WIDTH, 1, data bits per lane.
- N_LANES, 32, lane count (fixed at 32; SEL_W = 5).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer beat valid.
- in_ready  out  1  collector can accept a beat.
- in_data  in  WIDTH  beat payload.
- in_sel  in  5  destination lane, 0..31.
- in_last  in  1  beat closes the current word early.
- out_valid  out  1  assembled word available.
- out_ready  in  1  consumer accepts word.
- out_data  out  32*WIDTH  lane k at bits [k*WIDTH +: WIDTH].
- out_mask  out  32  bit k set if lane k was written in this word.

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high, sampled only on the clk rising edge.
- Reset values: state=FILL, out_valid=0, in_ready=1, out_data=0, out_mask=0.
- Reset mid-word or mid-hold: the partial or held word is discarded, with no output.
- Beat transfer occurs when in_valid && in_ready; word transfer occurs when out_valid && out_ready.
- FILL state:
  - in_ready=1, out_valid=0.
  - An accepted beat writes in_data into lane in_sel and sets mask[in_sel].
  - A rewrite of an already-written lane overwrites the data; the mask is unchanged.
  - Go to HOLD on the accepting edge if in_last=1, or if the mask becomes all ones after this write.
- HOLD state:
  - out_valid=1.
  - out_data and out_mask are stable until the word is transferred.
  - in_ready=out_ready, so the output drains and the next word starts in the same cycle.
- Word transfer with no simultaneous beat: clear mask and data, return to FILL.
- Word transfer with a simultaneous beat:
  - Clear, then apply the new beat as the first write of the new word.
  - If that beat has in_last=1, stay in HOLD with the 1-lane word.
- Latency: out_valid rises the cycle after the completing beat is accepted. Throughput is 1 beat/cycle, with no bubble between words.
- Unwritten lanes read 0.
- in_last on a beat that also fills the last lane gives a single completion, not two words.
- in_data, in_sel and in_last are ignored when in_valid=0 or in_ready=0.
- No combinational path from in_valid to out_valid. out_ready to in_ready is a permitted combinational path.

Optional Feature:
- Macro: DEMUX32_AUTO_SEL_EN.
- Defined:
  - in_sel is ignored. A 5-bit write pointer (reset 0) selects the lane and increments per accepted beat.
  - Pointer wrap 31->0 completes the word; in_last also completes it.
  - The pointer resets to 0 on every word completion.
- Undefined: the lane comes from in_sel only, and the pointer logic is absent.

Decomposition:
- Package demux32_pkg holds N_LANES=32, SEL_W=5, the state enum {FILL, HOLD}, and the all-ones mask constant.
- One sub-module, demux_32_dec: a combinational 5-to-32 one-hot decoder with an enable. It is the structural mirror of the 32:1 mux and drives the lane write enables.
- The top level holds the lane registers, mask, state and the optional pointer.

Test Plan:
- Single lane, WIDTH=1: write sel=5 data=1 with last=1 -> next cycle out_valid=1, out_mask=0x00000020, out_data=0x00000020.
- Full word: 32 beats sel=0..31 with data=sel[0] -> out_valid the cycle after beat 31, out_data=0xAAAAAAAA, out_mask=0xFFFFFFFF.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in HOLD -> in_ready=0 and out_data stable.
  - Then out_ready=1 with a simultaneous beat sel=3 -> the new word has mask=0x00000008.
- Overwrite: sel=7 data=1, then sel=7 data=0, then sel=0 last=1 -> out_mask=0x00000081, out_data=0x00000000.
- Reset mid-word: 10 beats, then rst for 1 cycle, then sel=1 last=1 -> out_mask=0x00000002 (no stale lanes).
- With DEMUX32_AUTO_SEL_EN:
  - 32 beats with random in_sel -> lanes filled 0..31 in order, mask=0xFFFFFFFF.
  - Then 3 beats with last on the 3rd -> mask=0x00000007.
